sram_cmd_ctrl: RTL and testbench
================================

Name: sram_cmd_ctrl

Overview:
- Front-end controller that sits directly upstream of the 32x9 single-port sky130 SRAM macro (1RW, 4-bit write mask, 5-bit address).
- Accepts valid/ready read/write commands and sequences the macro's chip-select, write-enable, mask, address and data pins.
- Captures read data after the macro's read latency and returns it on a valid/ready response channel.
- After reset, optionally sweeps the whole array to a fill value so the memory starts in a known state.

Parameters:
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W.
- DATA_W, 9, data width, including the macro's 9th bit.
- MASK_W, 4, write-mask width.
- READ_LAT, 1, clock edges from the macro capturing a read command until sram_dout is valid (1..3).
- INIT_EN, 1, when 1, run the fill sweep after every reset.
- INIT_VALUE, 9'h000, data written by the fill sweep.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command this cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wmask  in  MASK_W  write mask; ignored for reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts read data.
- rsp_data  out  DATA_W  read data.
- init_done  out  1  fill sweep complete; level signal.
- sram_csb  out  1  macro chip select, active low.
- sram_web  out  1  macro write enable, active low.
- sram_wmask  out  MASK_W  macro write mask.
- sram_addr  out  ADDR_W  macro address.
- sram_din  out  DATA_W  macro write data.
- sram_spare_wen  out  1  tied 0.
- sram_dout  in  DATA_W  macro read data.

Behaviour:
- Reset (async, takes effect immediately):
  - sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0.
  - rsp_valid=0, rsp_data=0.
  - init_done = ~INIT_EN; cmd_ready = ~INIT_EN.
  - State = INIT if INIT_EN, else IDLE.
  - Any outstanding read is dropped; no response is produced for it.
- Every sram_* output is registered. A command accepted at edge N drives the sram_* pins after edge N; the macro captures them at edge N+1.
- sram_csb is low for exactly one cycle per access and returns to 1 after edge N+1 unless another access follows.
- State INIT:
  - Issue one write per cycle: addresses 0,1,...,DEPTH-1, sram_web=0, sram_wmask all ones, sram_din=INIT_VALUE.
  - cmd_ready=0 throughout.
  - After issuing address DEPTH-1, go to IDLE; init_done goes to 1 on that same edge and stays 1 until the next reset.
  - The address counter wraps internally; it never issues address DEPTH.
- State IDLE:
  - cmd_ready=1. A command is accepted on cmd_valid & cmd_ready.
  - Write: drive sram_web=0, sram_wmask=cmd_wmask, sram_addr, sram_din; stay in IDLE. Back-to-back writes sustain one per cycle.
  - Read: drive sram_web=1, sram_addr; go to READ_WAIT. A read with cmd_wmask=0 is still a read.
  - A write with cmd_wmask=0 still pulses sram_csb low; the macro writes nothing.
- State READ_WAIT:
  - cmd_ready=0.
  - A down-counter loaded with READ_LAT expires at edge N+1+READ_LAT.
  - At that edge, register sram_dout into rsp_data, set rsp_valid=1, go to RESP.
- State RESP:
  - cmd_ready=0; rsp_valid and rsp_data are held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready: clear rsp_valid and go to IDLE. cmd_ready rises the cycle after the handshake; there is no combinational ready-to-ready path.
- Only one read is outstanding at a time. Writes are never accepted while a read is pending.
- cmd_* inputs are sampled only at an accepting edge; their changes at any other time are ignored.
- rsp_ready held high in advance causes no early handshake; the handshake needs rsp_valid.

Test Plan:
- INIT_EN=1, INIT_VALUE=9'h1A5, release rst -> 32 consecutive sram_csb=0 write cycles at addresses 0..31 with din 1A5 and mask F; init_done=1 after the 32nd; cmd_ready rises the same cycle; a read of addr 17 returns 1A5.
- Write addr 5, data 0x0AB, mask F; then read addr 5 with READ_LAT=1 and rsp_ready=1 -> rsp_valid rises 2 edges after read acceptance with rsp_data=0x0AB; exactly one sram_csb low pulse per command.
- Write addr 3 = 0x1FF mask F, then write addr 3 = 0x000 mask 4'b0001 -> read returns the bits under mask bit0 cleared, all others unchanged, per the macro's mask slicing.
- Read addr 9 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0 and cmd_valid ignored throughout; after the handshake cmd_ready=1 on the next cycle.
- Assert rst mid-INIT (at address 12) and again during READ_WAIT -> outputs go to reset values immediately; no rsp_valid appears; the sweep restarts from address 0.
- 8 back-to-back writes with cmd_valid held high -> 8 consecutive cycles of sram_csb=0, sram_web=0, addresses matching the accepted order.

Source files
------------

// File: rtl/sram_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// sram_cmd_ctrl
//   Front-end controller for a 32x9 single-port (1RW) SRAM macro with a
//   4-bit write mask. Accepts read/write commands on a valid/ready channel,
//   drives the macro pins from registers, captures read data after the
//   macro read latency and returns it on a valid/ready response channel.
//   After every reset it can sweep the whole array to INIT_VALUE.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_write                 1 = write, 0 = read
//   cmd_addr/wdata/wmask      command payload (wmask ignored for reads)
//   rsp_valid/rsp_ready       read response handshake
//   rsp_data                  read data, held stable until accepted
//   init_done                 fill sweep complete (level)
//   sram_csb/web/wmask/addr/din/spare_wen   registered macro pins
//   sram_dout                 macro read data
// ---------------------------------------------------------------------------
module sram_cmd_ctrl #(
  parameter int                ADDR_W     = 5,
  parameter int                DATA_W     = 9,
  parameter int                MASK_W     = 4,
  parameter int                READ_LAT   = 1,
  parameter bit                INIT_EN    = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [MASK_W-1:0] cmd_wmask,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  // status
  output logic              init_done,
  // macro pins
  output logic              sram_csb,
  output logic              sram_web,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_spare_wen,
  input  logic [DATA_W-1:0] sram_dout
);

  // Latency counter only needs to hold READ_LAT down to 0.
  localparam int CNT_W = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_IDLE      = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  localparam state_t RST_STATE = INIT_EN ? ST_INIT : ST_IDLE;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_addr_q, init_addr_d;
  logic [CNT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic                csb_q, csb_d;
  logic                web_q, web_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                init_done_q, init_done_d;

  logic                last_init_addr;
  logic                lat_expired;

  assign last_init_addr = (init_addr_q == {ADDR_W{1'b1}});
  assign lat_expired    = (lat_cnt_q == '0);

  // -------------------------------------------------------------------------
  // State register and all datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RST_STATE;
      init_addr_q <= '0;
      lat_cnt_q   <= '0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      wmask_q     <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      init_done_q <= ~INIT_EN;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      lat_cnt_q   <= lat_cnt_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      wmask_q     <= wmask_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      init_done_q <= init_done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:      if (last_init_addr)          state_d = ST_IDLE;
      ST_IDLE:      if (cmd_valid && !cmd_write) state_d = ST_READ_WAIT;
      ST_READ_WAIT: if (lat_expired)             state_d = ST_RESP;
      // rsp_valid is always set while in RESP, so rsp_ready alone completes it
      ST_RESP:      if (rsp_ready)               state_d = ST_IDLE;
      default:                                   state_d = RST_STATE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    // Strobes fall back to idle every cycle so each access is a single
    // cycle of csb low; address/data/mask simply hold their last value.
    csb_d       = 1'b1;
    web_d       = 1'b1;
    wmask_d     = wmask_q;
    addr_d      = addr_q;
    din_d       = din_q;
    init_addr_d = init_addr_q;
    lat_cnt_d   = lat_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    init_done_d = init_done_q;

    unique case (state_q)
      ST_INIT: begin
        csb_d       = 1'b0;
        web_d       = 1'b0;
        wmask_d     = '1;
        addr_d      = init_addr_q;
        din_d       = INIT_VALUE;
        // wraps to 0 after the last address, ready for the next reset-less use
        init_addr_d = init_addr_q + ADDR_W'(1);
        if (last_init_addr) init_done_d = 1'b1;
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          csb_d  = 1'b0;
          addr_d = cmd_addr;
          if (cmd_write) begin
            web_d   = 1'b0;
            wmask_d = cmd_wmask;
            din_d   = cmd_wdata;
          end else begin
            lat_cnt_d = CNT_W'(READ_LAT);
          end
        end
      end
      ST_READ_WAIT: begin
        // First edge here is the macro capture edge; the counter then
        // spends READ_LAT more edges before dout is sampled.
        if (lat_expired) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = sram_dout;
        end else begin
          lat_cnt_d = lat_cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // cmd_ready depends only on the state register: no path from rsp_ready.
  assign cmd_ready      = (state_q == ST_IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign init_done      = init_done_q;
  assign sram_csb       = csb_q;
  assign sram_web       = web_q;
  assign sram_wmask     = wmask_q;
  assign sram_addr      = addr_q;
  assign sram_din       = din_q;
  assign sram_spare_wen = 1'b0;

endmodule

// File: tb/tb_sram_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_cmd_ctrl
//   Directed bench for sram_cmd_ctrl with a behavioural 32x9 macro model.
//   Macro mask slicing used by the model: mask bit i (i<3) covers data bits
//   [2i+1:2i], mask bit 3 covers bits [8:6].
// ---------------------------------------------------------------------------
module tb_sram_cmd_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [4:0] cmd_addr;
  logic [8:0] cmd_wdata;
  logic [3:0] cmd_wmask;
  logic       rsp_valid, rsp_ready;
  logic [8:0] rsp_data;
  logic       init_done;
  logic       sram_csb, sram_web, sram_spare_wen;
  logic [3:0] sram_wmask;
  logic [4:0] sram_addr;
  logic [8:0] sram_din, sram_dout;

  int checks = 0;
  int errors = 0;

  sram_cmd_ctrl #(
    .ADDR_W(5), .DATA_W(9), .MASK_W(4), .READ_LAT(1),
    .INIT_EN(1'b1), .INIT_VALUE(9'h1A5)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_spare_wen(sram_spare_wen), .sram_dout(sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- macro model (read latency 1) ----------------
  logic [8:0] mem [0:31];
  logic [8:0] dout_q;
  int         csb_lo = 0;

  function automatic int grp(input int b);
    return (b >= 6) ? 3 : b / 2;
  endfunction

  always @(posedge clk) begin
    if (!sram_csb) begin
      csb_lo <= csb_lo + 1;
      if (!sram_web) begin
        for (int b = 0; b < 9; b++)
          if (sram_wmask[grp(b)]) mem[sram_addr][b] <= sram_din[b];
      end else begin
        dout_q <= mem[sram_addr];
      end
    end
  end
  assign sram_dout = dout_q;

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  // Presents a command and returns #1 after the accepting edge.
  task automatic issue(input logic w, input logic [4:0] a, input logic [8:0] d,
                       input logic [3:0] m, input string nm);
    int n;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wmask = m; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin tick; n++; end
    if (n >= 50) timeout(nm);
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string nm);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin tick; n++; end
    if (n >= 20) timeout(nm);
  endtask

  task automatic do_read(input logic [4:0] a, input logic [8:0] exp, input string nm);
    issue(1'b0, a, 9'h000, 4'h0, nm);
    rsp_ready = 1'b1;
    wait_rsp(nm);
    chk(nm, 32'(rsp_data), 32'(exp));
    tick;
    rsp_ready = 1'b0;
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    while (!init_done && n < 60) begin tick; n++; end
    if (n >= 60) timeout(nm);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       wr;
    logic [4:0] addr;
    logic [8:0] data;
    logic [3:0] mask;
    logic [8:0] exp;   // expected read data (reads only)
  } vec_t;

  vec_t vt [$];

  initial begin
    logic ok;
    int   c0;

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 1'b0;

    vt.push_back('{1'b0, 5'd17, 9'h000, 4'h0, 9'h1A5});
    vt.push_back('{1'b1, 5'd5,  9'h0AB, 4'hF, 9'h000});
    vt.push_back('{1'b0, 5'd5,  9'h000, 4'h0, 9'h0AB});
    vt.push_back('{1'b1, 5'd3,  9'h1FF, 4'hF, 9'h000});
    vt.push_back('{1'b1, 5'd3,  9'h000, 4'h1, 9'h000});
    vt.push_back('{1'b0, 5'd3,  9'h000, 4'hF, 9'h1FC});
    vt.push_back('{1'b1, 5'd7,  9'h000, 4'hF, 9'h000});
    vt.push_back('{1'b1, 5'd7,  9'h1FF, 4'h8, 9'h000});
    vt.push_back('{1'b0, 5'd7,  9'h000, 4'h0, 9'h1C0});
    vt.push_back('{1'b1, 5'd10, 9'h1FF, 4'h0, 9'h000});
    vt.push_back('{1'b0, 5'd10, 9'h000, 4'h0, 9'h1A5});
    vt.push_back('{1'b1, 5'd12, 9'h0AA, 4'h5, 9'h000});
    vt.push_back('{1'b0, 5'd12, 9'h000, 4'h0, 9'h1A6});
    vt.push_back('{1'b0, 5'd0,  9'h000, 4'h0, 9'h1A5});
    vt.push_back('{1'b1, 5'd31, 9'h155, 4'hF, 9'h000});
    vt.push_back('{1'b0, 5'd31, 9'h000, 4'h0, 9'h155});

    // ---- reset values ----
    repeat (2) tick;
    chk("rst csb/web",    32'({sram_csb, sram_web}), 32'h3);
    chk("rst wmask",      32'(sram_wmask), 32'h0);
    chk("rst addr",       32'(sram_addr), 32'h0);
    chk("rst din",        32'(sram_din), 32'h0);
    chk("rst rsp_valid",  32'(rsp_valid), 32'h0);
    chk("rst rsp_data",   32'(rsp_data), 32'h0);
    chk("rst init_done",  32'(init_done), 32'h0);
    chk("rst cmd_ready",  32'(cmd_ready), 32'h0);
    chk("spare_wen",      32'(sram_spare_wen), 32'h0);

    // ---- init sweep ----
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick;
      chk($sformatf("init pins %0d", i),
          32'({sram_csb, sram_web, sram_wmask, sram_addr, sram_din}),
          32'({1'b0, 1'b0, 4'hF, 5'(i), 9'h1A5}));
      chk($sformatf("init_done %0d", i), 32'({init_done, cmd_ready}),
          (i == 31) ? 32'h3 : 32'h0);
    end
    tick;
    chk("sweep stops", 32'(sram_csb), 32'h1);

    // ---- table-driven commands ----
    foreach (vt[k]) begin
      if (vt[k].wr)
        issue(1'b1, vt[k].addr, vt[k].data, vt[k].mask, $sformatf("vec%0d wr", k));
      else
        do_read(vt[k].addr, vt[k].exp, $sformatf("vec%0d rd", k));
    end

    // ---- read latency and single csb pulse ----
    c0 = csb_lo;
    rsp_ready = 1'b1;
    cmd_write = 1'b0; cmd_addr = 5'd5; cmd_valid = 1'b1;
    tick;                                   // accepting edge N
    cmd_valid = 1'b0;
    chk("lat pins", 32'({sram_csb, sram_web, sram_addr}), 32'({1'b0, 1'b1, 5'd5}));
    chk("lat N",    32'(rsp_valid), 32'h0);
    tick;
    chk("lat N+1",  32'({rsp_valid, sram_csb}), 32'h1);
    tick;
    chk("lat N+2",  32'(rsp_valid), 32'h1);
    chk("lat data", 32'(rsp_data), 32'h0AB);
    tick;
    chk("lat hs",   32'({rsp_valid, cmd_ready}), 32'h1);
    chk("lat pulses", 32'(csb_lo - c0), 32'h1);
    rsp_ready = 1'b0;

    // ---- response backpressure ----
    issue(1'b0, 5'd9, 9'h000, 4'h0, "bp issue");
    wait_rsp("bp wait");
    cmd_write = 1'b1; cmd_addr = 5'd9; cmd_wdata = 9'h000; cmd_wmask = 4'hF;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("bp hold %0d", i),
          32'({rsp_valid, cmd_ready, sram_csb, rsp_data}),
          32'({1'b1, 1'b0, 1'b1, 9'h1A5}));
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick;
    chk("bp release", 32'({rsp_valid, cmd_ready}), 32'h1);
    rsp_ready = 1'b0;
    do_read(5'd9, 9'h1A5, "bp write ignored");

    // ---- 8 back-to-back writes ----
    cmd_write = 1'b1; cmd_wmask = 4'hF; cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cmd_addr = 5'(20 + i); cmd_wdata = 9'(9'h100 + i);
      tick;
      chk($sformatf("b2b %0d", i), 32'({sram_csb, sram_web, sram_addr}),
          32'({1'b0, 1'b0, 5'(20 + i)}));
    end
    cmd_valid = 1'b0;
    tick;
    chk("b2b end", 32'(sram_csb), 32'h1);
    do_read(5'd23, 9'h103, "b2b readback");

    // ---- reset in the middle of the sweep ----
    rst = 1'b1;
    tick;
    rst = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      tick;
      if (!sram_csb && sram_addr == 5'd12) ok = 1'b1;
    end
    if (!ok) timeout("init addr 12");
    rst = 1'b1;
    #1;
    chk("midinit rst", 32'({sram_csb, sram_web, sram_addr, init_done, cmd_ready}),
        32'({1'b1, 1'b1, 5'd0, 1'b0, 1'b0}));
    tick;
    rst = 1'b0;
    tick;
    chk("sweep restart", 32'({sram_csb, sram_addr}), 32'({1'b0, 5'd0}));
    wait_init("midinit done");

    // ---- reset while a read is pending ----
    tick;
    rsp_ready = 1'b1;
    issue(1'b0, 5'd20, 9'h000, 4'h0, "rw issue");
    rst = 1'b1;
    #1;
    chk("rw rst", 32'({rsp_valid, sram_csb, rsp_data}), 32'({1'b0, 1'b1, 9'h000}));
    tick;
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (rsp_valid) ok = 1'b0;
    end
    chk("rw no rsp", 32'(ok), 32'h1);
    rsp_ready = 1'b0;
    wait_init("rw init");
    do_read(5'd20, 9'h1A5, "rw refill");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
